// File: rtl/tank_sprite_fetch.sv
// Tank sprite row fetch: fills a line buffer from the sprite ROM during blanking, then serves
// per-pixel indices with a transparency-masked tank_on qualifier, one clock after DrawX.
module tank_sprite_fetch #(
  parameter int          SIZE        = 32,
  parameter int          ADDR_W      = 10,
  parameter logic [15:0] TRANSP_MASK = 16'h9919
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              line_start,
  input  logic [9:0]        line_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        TankX,
  input  logic [9:0]        TankY,
  input  logic [1:0]        dir,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pixel_index,
  output logic              tank_on
);

  localparam int LW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     r_q, r_d;
  logic [LW-1:0]     c_q, c_d;
  logic [1:0]        d_q, d_d;
  logic [9:0]        tx_q, tx_d;
  logic              row_valid_q, row_valid_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        pixel_index_q, pixel_index_d;
  logic              tank_on_q, tank_on_d;

  logic [3:0]        linebuf [SIZE];
  logic              lb_we;
  logic [LW-1:0]     lb_waddr;
  logic [9:0]        line_r;
  logic [9:0]        col;
  logic [3:0]        lb_rd;
  logic              hit;

  // Mirror/rotate the displayed (row, col) back to the stored sprite orientation.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [LW-1:0] r,
                                                 input logic [LW-1:0] c,
                                                 input logic [1:0]    d);
    logic [LW-1:0] sr;
    logic [LW-1:0] sc;
    case (d)
      2'd0:    begin sr = r;  sc = c;  end
      2'd1:    begin sr = ~c; sc = r;  end
      2'd2:    begin sr = ~r; sc = ~c; end
      default: begin sr = c;  sc = ~r; end
    endcase
    return ADDR_W'({sr, sc});
  endfunction

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    tx_d        = tx_q;
    row_valid_d = row_valid_q;
    rom_addr_d  = rom_addr_q;
    lb_we       = 1'b0;
    lb_waddr    = c_q - LW'(1);
    line_r      = line_y - TankY;

    case (state_q)
      FETCH: begin
        // ROM data arriving now belongs to the column issued last cycle.
        lb_we = (c_q != '0);
        if (c_q == LW'(SIZE - 1)) begin
          state_d = DRAIN;
        end else begin
          c_d        = c_q + LW'(1);
          rom_addr_d = src_addr(r_q, c_q + LW'(1), d_q);
        end
      end
      DRAIN: begin
        lb_we       = 1'b1;
        lb_waddr    = LW'(SIZE - 1);
        row_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: ;
    endcase

    // A new line always wins, aborting any fetch in progress.
    if (line_start) begin
      tx_d        = TankX;
      d_d         = dir;
      r_d         = line_r[LW-1:0];
      c_d         = '0;
      row_valid_d = 1'b0;
      if (line_r < 10'(SIZE)) begin
        state_d    = FETCH;
        rom_addr_d = src_addr(line_r[LW-1:0], '0, dir);
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    col           = DrawX - tx_q;
    lb_rd         = linebuf[col[LW-1:0]];
    hit           = row_valid_q && (col < 10'(SIZE));
    pixel_index_d = hit ? lb_rd : 4'd0;
    tank_on_d     = hit && !TRANSP_MASK[lb_rd];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      r_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      tx_q          <= '0;
      row_valid_q   <= 1'b0;
      rom_addr_q    <= '0;
      pixel_index_q <= '0;
      tank_on_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      c_q           <= c_d;
      d_q           <= d_d;
      tx_q          <= tx_d;
      row_valid_q   <= row_valid_d;
      rom_addr_q    <= rom_addr_d;
      pixel_index_q <= pixel_index_d;
      tank_on_q     <= tank_on_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (lb_we) linebuf[lb_waddr] <= rom_data;
  end

  assign rom_addr    = rom_addr_q;
  assign pixel_index = pixel_index_q;
  assign tank_on     = tank_on_q;

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Randomized bench for tank_sprite_fetch against a line-level reference model of the sprite row.
module tb_tank_sprite_fetch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] line_y = '0;
  logic [9:0] DrawX = '0;
  logic [9:0] TankX = '0;
  logic [9:0] TankY = '0;
  logic [1:0] dir = '0;
  logic [9:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] pixel_index;
  logic       tank_on;

  tank_sprite_fetch #(.SIZE(32), .ADDR_W(10), .TRANSP_MASK(16'h9919)) dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_y(line_y),
    .DrawX(DrawX), .TankX(TankX), .TankY(TankY), .dir(dir),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_index(pixel_index), .tank_on(tank_on)
  );

  always #5 Clk = ~Clk;

  logic [3:0]  rom [1024];
  logic [15:0] transp = 16'h9919;

  always @(posedge Clk) rom_data <= rom[rom_addr];

  int total = 0;
  int bad   = 0;

  // Reference model: the row the bench believes is currently displayable.
  bit m_valid = 1'b0;
  int m_r = 0, m_tx = 0, m_d = 0, m_addr = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  function automatic int src_addr(input int r, input int c, input int d);
    int sr, sc;
    case (d)
      0:       begin sr = r;      sc = c;      end
      1:       begin sr = 31 - c; sc = r;      end
      2:       begin sr = 31 - r; sc = 31 - c; end
      default: begin sr = c;      sc = 31 - r; end
    endcase
    return sr * 32 + sc;
  endfunction

  function automatic int exp_idx(input int x);
    int col;
    col = (x - m_tx) & 1023;
    if (!m_valid || col >= 32) return 0;
    return int'(rom[src_addr(m_r, col, m_d)]);
  endfunction

  function automatic int exp_on(input int x);
    int col, idx;
    col = (x - m_tx) & 1023;
    if (!m_valid || col >= 32) return 0;
    idx = int'(rom[src_addr(m_r, col, m_d)]);
    return transp[idx] ? 0 : 1;
  endfunction

  // Pulse line_start, then check nchk issued addresses (32 = complete the fetch).
  task automatic do_line(input int ly, input int ty, input int tx, input int d, input int nchk);
    int r;
    line_start = 1'b1;
    line_y = 10'(ly); TankY = 10'(ty); TankX = 10'(tx); dir = 2'(d);
    step;
    line_start = 1'b0;
    r = (ly - ty) & 1023;
    m_valid = 1'b0; m_tx = tx; m_d = d; m_r = r;
    if (r >= 32) begin
      for (int k = 0; k < 4; k++) begin
        chk("addr_hold_miss", int'(rom_addr), m_addr);
        step;
      end
      return;
    end
    for (int k = 0; k < nchk; k++) begin
      m_addr = src_addr(r, k, d);
      chk("fetch_addr", int'(rom_addr), m_addr);
      DrawX = 10'(tx + k);
      step;
      chk("pix_during_fetch", int'(pixel_index), exp_idx(tx + k));
    end
    if (nchk == 32) begin
      // DRAIN cycle: row not yet valid for this display sample.
      DrawX = 10'(tx);
      step;
      chk("pix_in_drain", int'(pixel_index), 0);
      chk("addr_hold_drain", int'(rom_addr), m_addr);
      m_valid = 1'b1;
    end
  endtask

  task automatic sweep(input int x0, input int n);
    int x;
    for (int i = 0; i < n; i++) begin
      x = (x0 + i) & 1023;
      DrawX = 10'(x);
      step;
      chk("pixel_index", int'(pixel_index), exp_idx(x));
      chk("tank_on", int'(tank_on), exp_on(x));
    end
  endtask

  initial begin
    int ty, ly, tx, d;
    for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom_range(0, 15));

    #2 Reset = 1'b1;
    #10;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_pixel_index", int'(pixel_index), 0);
    chk("rst_tank_on", int'(tank_on), 0);
    @(negedge Clk) Reset = 1'b0;
    step;

    // Directed row, all four facings.
    for (int dd = 0; dd < 4; dd++) begin
      do_line(105, 100, 200, dd, 32);
      sweep(196, 40);
    end

    // Misses above and below the sprite.
    do_line(99, 100, 200, 0, 32);
    sweep(0, 640);
    do_line(132, 100, 200, 1, 32);
    sweep(180, 60);

    // Right-edge clip and wrapped column at the left edge.
    do_line(110, 100, 620, 2, 32);
    sweep(600, 40);
    sweep(0, 8);
    do_line(131, 100, 5, 3, 32);
    sweep(0, 42);

    // Abort: second line_start ten cycles into the fetch.
    do_line(105, 100, 300, 1, 10);
    do_line(120, 100, 300, 2, 32);
    sweep(296, 40);

    // Randomized lines.
    for (int it = 0; it < 10; it++) begin
      ty = $urandom_range(0, 479);
      ly = (ty + $urandom_range(0, 40) - 4) & 1023;
      tx = $urandom_range(0, 639);
      d  = $urandom_range(0, 3);
      do_line(ly, ty, tx, d, 32);
      sweep(tx - 3, 38);
    end

    // Reset during the 15th FETCH cycle.
    do_line(107, 100, 400, 0, 32);
    sweep(400, 4);
    do_line(114, 100, 400, 1, 14);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_rom_addr", int'(rom_addr), 0);
    chk("midrst_pixel_index", int'(pixel_index), 0);
    chk("midrst_tank_on", int'(tank_on), 0);
    @(negedge Clk) Reset = 1'b0;
    m_valid = 1'b0; m_addr = 0;
    step;
    sweep(396, 40);
    for (int k = 0; k < 36; k++) begin
      chk("post_rst_addr", int'(rom_addr), m_addr);
      step;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
